// File: rtl/pipe_arb_pkg.sv
// Shared constants and types for the pipelined issue arbiter.
package pipe_arb_pkg;

    localparam int W       = 10;
    localparam int LAT     = 3;
    localparam int ID_MAXW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic               valid;
        logic [ID_MAXW-1:0] id;
    } tag_t;

endpackage

// File: rtl/pipe_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, with wrap.
module pipe_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            found_o
);

    logic [NREQ-1:0] rot;
    int              sum;

    always_comb begin
        rot     = NREQ'({req_i, req_i} >> ptr_i);
        found_o = 1'b0;
        sum     = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found_o && rot[k]) begin
                found_o = 1'b1;
                sum     = int'(ptr_i) + k;
            end
        end
        if (sum >= NREQ) sum = sum - NREQ;
        idx_o = IDW'(sum);
        gnt_o = found_o ? ({{(NREQ-1){1'b0}}, 1'b1} << idx_o) : '0;
    end

endmodule

// File: rtl/pipe_issue_arbiter.sv
// Round-robin issue arbiter sharing one fixed-latency arithmetic pipeline, with run/drain control.
// Define PIPE_ARB_STATS_EN to add per-requester saturating issue counters on stat_cnt.
module pipe_issue_arbiter
    import pipe_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*W-1:0] req_c,
    input  logic [NREQ*W-1:0] req_d,
    output logic [W-1:0]      pipe_a,
    output logic [W-1:0]      pipe_b,
    output logic [W-1:0]      pipe_c,
    output logic [W-1:0]      pipe_d,
    input  logic [W-1:0]      pipe_f,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_f,
    output logic              busy,
    output logic              idle_pulse
`ifdef PIPE_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0] stat_cnt
`endif
);

    // Tag slots: one beside the operand register, one for the pipeline input
    // capture, then LAT stages, so the last slot lines up with pipe_f.
    localparam int TAGS = LAT + 2;

    state_e              state_q, state_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    tag_t [TAGS-1:0]     tag_q;
    tag_t                tag0_d;
    logic [W-1:0]        pa_q, pb_q, pc_q, pd_q;
    logic [W-1:0]        sel_a, sel_b, sel_c, sel_d;
    logic [NREQ-1:0]     pick_gnt;
    logic [IDW-1:0]      pick_idx;
    logic                pick_found;
    logic                run, xfer, tags_empty;

    pipe_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    assign run       = (state_q == RUN);
    assign req_ready = run ? pick_gnt : '0;
    assign xfer      = run & pick_found;

    // Invalid slots are kept all-zero, so one compare covers every valid bit.
    assign tags_empty = (tag_q == '0);

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_c = '0;
        sel_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
                sel_c = req_c[i*W +: W];
                sel_d = req_d[i*W +: W];
            end
        end
    end

    always_comb begin
        tag0_d = '0;
        if (xfer) begin
            tag0_d.valid         = 1'b1;
            tag0_d.id[IDW-1:0]   = pick_idx;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) ptr_d = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        idle_pulse = 1'b0;
        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = DRAIN;
            DRAIN: begin
                if (enable) begin
                    state_d = RUN;
                end else if (tags_empty) begin
                    state_d    = IDLE;
                    idle_pulse = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            tag_q   <= '0;
            pa_q    <= '0;
            pb_q    <= '0;
            pc_q    <= '0;
            pd_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            tag_q   <= {tag_q[TAGS-2:0], tag0_d};
            if (xfer) begin
                pa_q <= sel_a;
                pb_q <= sel_b;
                pc_q <= sel_c;
                pd_q <= sel_d;
            end
        end
    end

    assign pipe_a    = pa_q;
    assign pipe_b    = pb_q;
    assign pipe_c    = pc_q;
    assign pipe_d    = pd_q;
    assign rsp_valid = tag_q[TAGS-1].valid;
    assign rsp_id    = tag_q[TAGS-1].id[IDW-1:0];
    assign rsp_f     = pipe_f;
    assign busy      = (state_q != IDLE) || !tags_empty;

`ifdef PIPE_ARB_STATS_EN
    logic [NREQ-1:0][15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (xfer && pick_gnt[i] && (cnt_q[i] != 16'hFFFF)) cnt_q[i] <= cnt_q[i] + 16'd1;
            end
        end
    end

    assign stat_cnt = cnt_q;
`endif

endmodule
